text_renderer: RTL and testbench
================================

Name: text_renderer

Overview:
- Character-mode pixel pipeline between the VGA timing generator and the 8x16 glyph ROM.
- For each pixel coordinate it:
  - computes the text-buffer cell address;
  - forms the glyph ROM address {ascii[6:0], row[3:0]};
  - selects the pixel bit from the returned 8-bit row;
  - emits 12-bit RGB with syncs delayed to match.
- Adds a blinking inverse-video cursor.

Parameters:
- H_CHARS, 80, text columns (640/8)
- V_CHARS, 30, text rows (480/16)
- FG_RGB, 12'hFFF, foreground colour (4:4:4)
- BG_RGB, 12'h008, background colour inside the text area
- BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous reset, active-low
- pix_x  in  10  current pixel column from timing generator
- pix_y  in  10  current pixel row
- video_on  in  1  active-video flag
- hsync_in  in  1  horizontal sync (active-low)
- vsync_in  in  1  vertical sync (active-low)
- text_addr  out  12  text-buffer cell index = row*H_CHARS+col, combinational
- text_char  in  7  ASCII from text buffer, valid 1 cycle after text_addr (synchronous-read RAM)
- font_addr  out  11  glyph ROM address {text_char, glyph_row}, combinational
- font_data  in  8  glyph row, combinational from font_addr, MSB = leftmost pixel
- cursor_en  in  1  cursor enable
- cursor_col  in  7  cursor column
- cursor_row  in  5  cursor row
- rgb  out  12  pixel colour
- hsync_out  out  1  hsync delayed by 2
- vsync_out  out  1  vsync delayed by 2
- de_out  out  1  video_on delayed by 2

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. All flops are reset.
- Reset values:
  - rgb=0, de_out=0.
  - hsync_out=1, vsync_out=1 (inactive).
  - Pipeline valid bits 0.
  - Blink counter 0, blink_phase=1 (cursor visible).
- Stage 0 (combinational):
  - col=pix_x[9:3], row=pix_y[8:4].
  - in_area = video_on && col<H_CHARS && row<V_CHARS.
  - text_addr = in_area ? row*H_CHARS+col : 0 (12-bit, no overflow: max 2399).
- Stage 1 register:
  - Captures pix_x[2:0], pix_y[3:0], in_area, video_on, hsync_in, vsync_in.
  - Captures cursor_hit = cursor_en && col==cursor_col && row==cursor_row.
- Cycle 1 (combinational):
  - font_addr = {text_char, s1_yrow}.
  - bit = font_data[7 - s1_xcol].
- Stage 2 register (outputs):
  - !s1_video_on -> rgb=0.
  - s1_video_on && !s1_in_area -> rgb=0.
  - in_area: on = bit XOR (s1_cursor_hit && blink_phase); rgb = on ? FG_RGB : BG_RGB.
  - Syncs and de_out are pipelined identically.
- Latency: exactly 2 clk from pix_x/pix_y/syncs input to rgb/hsync_out/vsync_out/de_out. No stalls, one pixel per clock.
- ASCII codes with no glyph (ROM returns 0) render as background. text_char bit range is 7 bits; no masking needed.
- Blink timer:
  - frame_tick = stage-0 condition pix_x==0 && pix_y==0 && video_on, edge-qualified (fires once per frame even if held multiple cycles).
  - Counter increments on frame_tick. At BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
  - cursor_en=0 leaves the counter running.
- Cursor out of range (col≥H_CHARS or row≥V_CHARS): never hits, no cursor drawn.
- Reset mid-frame: outputs go to reset values immediately. Pipeline refills and rgb is valid 2 clk after deassertion.

Decomposition:
- Package text_pkg:
  - CHAR_W=8, CHAR_H=16.
  - typedef logic [11:0] rgb_t.
  - typedef logic [6:0] ascii_t.
  - Default H_CHARS/V_CHARS.
- Sub-module cursor_blink (frame_tick edge detect, counter, blink_phase). Pipeline stays in text_renderer.

Test Plan:
- Reset check: assert rst_n=0 mid-line -> rgb=0, hsync_out=vsync_out=1, de_out=0 same cycle; after release with pix_x=0, pix_y=0 -> de_out=1 exactly 2 clk later.
- Address check: pix_x=17, pix_y=35 -> text_addr=2*80+2=162. Buffer model returns 'A' (65) next cycle with pix_y[3:0]=3 -> font_addr=1043.
- Glyph and colour: model font_data=8'b00011000 for '1' row 4; sweep pix_x[2:0]=0..7 -> rgb sequence BG,BG,BG,FG,FG,BG,BG,BG at 2-clk latency.
- Blanking: pix_y=480 or video_on=0 -> rgb=0, text_addr=0. pix_x=640 with video_on=1 -> rgb=0.
- Cursor: cursor_en=1, cursor_col=2, cursor_row=2, glyph 0 -> that cell's 128 pixels are FG while blink_phase=1. After 30 frame_ticks they become BG; after 60, FG again.
- Sync alignment: random hsync_in/vsync_in toggles -> outputs equal inputs delayed exactly 2 clk, and aligned with rgb.

Source files
------------

// File: rtl/text_pkg.sv
// Shared types and geometry for the character-mode text renderer.
package text_pkg;

  localparam int CHAR_W      = 8;
  localparam int CHAR_H      = 16;
  localparam int H_CHARS_DEF = 80;
  localparam int V_CHARS_DEF = 30;

  typedef logic [11:0] rgb_t;
  typedef logic [6:0]  ascii_t;

  // Everything stage 1 has to carry forward for one pixel.
  typedef struct packed {
    logic [2:0] xcol;
    logic [3:0] yrow;
    logic       in_area;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       cursor_hit;
  } s1_t;

endpackage

// File: rtl/text_renderer_if.sv
// Video timing in, text/glyph memory buses, and pixel/sync outputs of the renderer.
interface text_renderer_if;
  import text_pkg::*;

  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [11:0] text_addr;
  ascii_t      text_char;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  rgb_t        rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;

  modport master (
    output pix_x, pix_y, video_on, hsync_in, vsync_in,
    output text_char, font_data, cursor_en, cursor_col, cursor_row,
    input  text_addr, font_addr, rgb, hsync_out, vsync_out, de_out
  );

  modport slave (
    input  pix_x, pix_y, video_on, hsync_in, vsync_in,
    input  text_char, font_data, cursor_en, cursor_col, cursor_row,
    output text_addr, font_addr, rgb, hsync_out, vsync_out, de_out
  );

endinterface

// File: rtl/cursor_blink.sv
// Once-per-frame tick detection and the cursor blink half-period counter.
module cursor_blink #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_cond,
    output logic blink_phase
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic          cond_q;
    logic [CW-1:0] cnt;
    logic          frame_tick;

    // The top-left pixel condition may be held for several clocks; count only its rising edge.
    assign frame_tick = frame_cond && !cond_q;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_q      <= 1'b0;
            cnt         <= '0;
            blink_phase <= 1'b1;
        end else begin
            cond_q <= frame_cond;
            if (frame_tick) begin
                if (cnt == CW'(BLINK_FRAMES - 1)) begin
                    cnt         <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/text_renderer.sv
// Two-stage pixel pipeline: cell address -> glyph row lookup -> RGB, syncs delayed to match.
module text_renderer
    import text_pkg::*;
#(
    parameter int   H_CHARS      = H_CHARS_DEF,
    parameter int   V_CHARS      = V_CHARS_DEF,
    parameter rgb_t FG_RGB       = 12'hFFF,
    parameter rgb_t BG_RGB       = 12'h008,
    parameter int   BLINK_FRAMES = 30
) (
    input logic            clk,
    input logic            rst_n,
    text_renderer_if.slave bus
);

    logic [6:0] col;
    logic [4:0] row;
    logic       in_area;
    logic       cursor_hit;
    logic       frame_cond;
    logic       blink_phase;
    logic       pix_bit;
    logic       pix_on;
    rgb_t       rgb_d;
    s1_t        s1;
    rgb_t       rgb_q;
    logic       hs_q;
    logic       vs_q;
    logic       de_q;

    // Stage 0: cell coordinates and text-buffer address.
    assign col        = bus.pix_x[9:3];
    assign row        = bus.pix_y[8:4];
    assign in_area    = bus.video_on && (int'(col) < H_CHARS) && (int'(row) < V_CHARS);
    assign bus.text_addr = in_area ? (12'(row) * 12'(H_CHARS) + 12'(col)) : 12'd0;
    assign cursor_hit = in_area && bus.cursor_en &&
                        (col == bus.cursor_col) && (row == bus.cursor_row);
    assign frame_cond = (bus.pix_x == 10'd0) && (bus.pix_y == 10'd0) && bus.video_on;

    cursor_blink #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_cond (frame_cond),
        .blink_phase(blink_phase)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '{xcol: 3'd0, yrow: 4'd0, in_area: 1'b0, video_on: 1'b0,
                    hsync: 1'b1, vsync: 1'b1, cursor_hit: 1'b0};
        end else begin
            s1 <= '{xcol: bus.pix_x[2:0], yrow: bus.pix_y[3:0], in_area: in_area,
                    video_on: bus.video_on, hsync: bus.hsync_in, vsync: bus.vsync_in,
                    cursor_hit: cursor_hit};
        end
    end

    // Cycle 1: text_char has arrived from the synchronous buffer; glyph ROM answers combinationally.
    assign bus.font_addr = {bus.text_char, s1.yrow};
    assign pix_bit       = bus.font_data[3'd7 - s1.xcol];
    assign pix_on        = pix_bit ^ (s1.cursor_hit && blink_phase);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rgb_d = '0;
        if (s1.video_on && s1.in_area) begin
            rgb_d = pix_on ? FG_RGB : BG_RGB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            de_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= s1.hsync;
            vs_q  <= s1.vsync;
            de_q  <= s1.video_on;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.hsync_out = hs_q;
    assign bus.vsync_out = vs_q;
    assign bus.de_out    = de_q;

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer with a synchronous text-buffer model and a tiny glyph ROM model.
module tb_text_renderer;
    import text_pkg::*;

    localparam rgb_t FG = 12'hFFF;
    localparam rgb_t BG = 12'h008;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    text_renderer_if bus ();

    text_renderer #(
        .H_CHARS     (80),
        .V_CHARS     (30),
        .FG_RGB      (FG),
        .BG_RGB      (BG),
        .BLINK_FRAMES(30)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ascii_t mem [4096];

    // Synchronous-read text buffer: data one clock after the address.
    always @(posedge clk) bus.text_char <= mem[bus.text_addr];

    function automatic logic [7:0] font_rom(input logic [10:0] a);
        case (a)
            {7'd49, 4'd4}: font_rom = 8'b0001_1000;
            {7'd65, 4'd3}: font_rom = 8'b0011_1100;
            {7'd65, 4'd4}: font_rom = 8'b0110_0110;
            default:       font_rom = 8'h00;
        endcase
    endfunction

    always_comb bus.font_data = font_rom(bus.font_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One frame-start pulse, held for 'hold' clocks, then the beam moves on.
    task automatic tick_frame(input int hold);
        bus.pix_x    = 10'd0;
        bus.pix_y    = 10'd0;
        bus.video_on = 1'b1;
        repeat (hold) @(negedge clk);
        bus.pix_x = 10'd1;
        @(negedge clk);
    endtask

    // Stream all 128 pixels of cell (col 2, row 2) back to back and count correct outputs.
    task automatic check_cell(input string name, input logic vis);
        int         good;
        int         p;
        logic [7:0] g;
        logic       b;
        rgb_t       e;
        good = 0;
        bus.video_on = 1'b1;
        for (int k = 0; k < 130; k++) begin
            if (k >= 2) begin
                p = k - 2;
                g = font_rom({mem[162], 4'(p / 8)});
                b = g[7 - (p % 8)];
                e = (b ^ vis) ? FG : BG;
                if (bus.rgb === e) good++;
            end
            if (k < 128) begin
                bus.pix_x = 10'(16 + k % 8);
                bus.pix_y = 10'(32 + k / 8);
            end
            @(negedge clk);
        end
        check(name, 32'(good), 32'd128);
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        v;
        logic [11:0] addr;
        logic [10:0] font;
        rgb_t        rgb;
    } vec_t;

    vec_t vecs [9];

    logic hq [40];
    logic vq [40];
    logic dq [40];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 7'd0;
        mem[0]   = 7'd49;
        mem[162] = 7'd65;

        vecs[0] = '{10'd17,  10'd35,  1'b1, 12'd162,  11'd1043, BG};
        vecs[1] = '{10'd19,  10'd35,  1'b1, 12'd162,  11'd1043, FG};
        vecs[2] = '{10'd3,   10'd4,   1'b1, 12'd0,    11'd788,  FG};
        vecs[3] = '{10'd7,   10'd4,   1'b1, 12'd0,    11'd788,  BG};
        vecs[4] = '{10'd17,  10'd480, 1'b1, 12'd0,    11'd784,  12'h000};
        vecs[5] = '{10'd17,  10'd35,  1'b0, 12'd0,    11'd787,  12'h000};
        vecs[6] = '{10'd640, 10'd35,  1'b1, 12'd0,    11'd787,  12'h000};
        vecs[7] = '{10'd639, 10'd479, 1'b1, 12'd2399, 11'd15,   BG};
        vecs[8] = '{10'd8,   10'd16,  1'b1, 12'd81,   11'd0,    BG};

        rst_n          = 1'b0;
        bus.pix_x      = 10'd5;
        bus.pix_y      = 10'd5;
        bus.video_on   = 1'b0;
        bus.hsync_in   = 1'b1;
        bus.vsync_in   = 1'b1;
        bus.cursor_en  = 1'b0;
        bus.cursor_col = 7'd2;
        bus.cursor_row = 5'd2;

        repeat (3) @(negedge clk);
        check("reset_rgb", 32'(bus.rgb), 32'h0);
        check("reset_hsync", 32'(bus.hsync_out), 32'd1);
        check("reset_vsync", 32'(bus.vsync_out), 32'd1);
        check("reset_de", 32'(bus.de_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: hold each vector, check address now, glyph address after 1 clk, colour after 2.
        for (int i = 0; i < 9; i++) begin
            bus.pix_x    = vecs[i].x;
            bus.pix_y    = vecs[i].y;
            bus.video_on = vecs[i].v;
            #1;
            check($sformatf("text_addr[%0d]", i), 32'(bus.text_addr), 32'(vecs[i].addr));
            @(negedge clk);
            check($sformatf("font_addr[%0d]", i), 32'(bus.font_addr), 32'(vecs[i].font));
            @(negedge clk);
            check($sformatf("rgb[%0d]", i), 32'(bus.rgb), 32'(vecs[i].rgb));
            check($sformatf("de[%0d]", i), 32'(bus.de_out), 32'(vecs[i].v));
        end

        // Back-to-back sweep across one glyph row: one pixel per clock, 2-clk latency.
        begin
            rgb_t sweep_exp [8];
            sweep_exp = '{BG, BG, BG, FG, FG, BG, BG, BG};
            bus.pix_y    = 10'd4;
            bus.video_on = 1'b1;
            for (int c = 0; c < 10; c++) begin
                if (c >= 2) check($sformatf("sweep_rgb[%0d]", c - 2), 32'(bus.rgb), 32'(sweep_exp[c-2]));
                if (c < 8) bus.pix_x = 10'(c);
                @(negedge clk);
            end
        end

        // Random sync/video toggles: outputs track inputs exactly 2 clocks later.
        bus.pix_x = 10'd100;
        bus.pix_y = 10'd100;
        for (int c = 0; c < 42; c++) begin
            if (c >= 2) begin
                check("sync_h", 32'(bus.hsync_out), 32'(hq[c-2]));
                check("sync_v", 32'(bus.vsync_out), 32'(vq[c-2]));
                check("sync_de", 32'(bus.de_out), 32'(dq[c-2]));
                check("sync_rgb", 32'(bus.rgb), dq[c-2] ? 32'(BG) : 32'h0);
            end
            if (c < 40) begin
                hq[c] = 1'($urandom_range(0, 1));
                vq[c] = 1'($urandom_range(0, 1));
                dq[c] = 1'($urandom_range(0, 1));
                bus.hsync_in = hq[c];
                bus.vsync_in = vq[c];
                bus.video_on = dq[c];
            end
            @(negedge clk);
        end

        // Mid-line asynchronous reset, then refill from the top-left pixel.
        bus.video_on = 1'b1;
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_rgb", 32'(bus.rgb), 32'(BG));
        #2 rst_n = 1'b0;
        #1;
        check("midreset_rgb", 32'(bus.rgb), 32'h0);
        check("midreset_hsync", 32'(bus.hsync_out), 32'd1);
        check("midreset_vsync", 32'(bus.vsync_out), 32'd1);
        check("midreset_de", 32'(bus.de_out), 32'd0);
        @(negedge clk);
        bus.pix_x    = 10'd0;
        bus.pix_y    = 10'd0;
        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1;
        rst_n        = 1'b1;
        @(negedge clk);
        check("refill_de_1clk", 32'(bus.de_out), 32'd0);
        @(negedge clk);
        check("refill_de_2clk", 32'(bus.de_out), 32'd1);
        check("refill_rgb_2clk", 32'(bus.rgb), 32'(BG));

        // Cursor blink: fresh reset with no frame start so the count begins at 0, phase visible.
        rst_n        = 1'b0;
        bus.video_on = 1'b0;
        bus.pix_x    = 10'd5;
        bus.pix_y    = 10'd5;
        @(negedge clk);
        rst_n    = 1'b1;
        mem[162] = 7'd0;
        @(negedge clk);
        bus.cursor_en = 1'b1;
        check_cell("cursor_visible_blank", 1'b1);
        mem[162] = 7'd65;
        check_cell("cursor_inverts_glyph", 1'b1);
        mem[162] = 7'd0;

        bus.cursor_en = 1'b0;
        for (int i = 0; i < 10; i++) tick_frame(1 + i % 3);
        bus.cursor_en = 1'b1;
        for (int i = 0; i < 19; i++) tick_frame(1 + i % 3);
        check_cell("cursor_after_29_ticks", 1'b1);
        tick_frame(2);
        check_cell("cursor_after_30_ticks", 1'b0);
        for (int i = 0; i < 30; i++) tick_frame(1 + i % 3);
        check_cell("cursor_after_60_ticks", 1'b1);

        bus.cursor_col = 7'd100;
        check_cell("cursor_out_of_range", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
